// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one FP adder between N requesters: grants one
// requester, walks the adder's start/A/B/result handshakes and returns the tagged sum.
module fp_add_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  output logic [N-1:0]    req_ack,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [31:0]     rsp_z,
  output logic            add_start,
  input  logic            add_idle,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  output logic            add_a_stb,
  output logic            add_b_stb,
  input  logic            add_a_ack,
  input  logic            add_b_ack,
  input  logic [31:0]     add_z,
  input  logic            add_z_stb,
  input  logic            add_valid,
  output logic            add_z_ack,
  output logic            busy,
  output logic [15:0]     ops_done
);

  typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT_Z, WAIT_V, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] cur_id_q;
  logic [N-1:0]   req_ack_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_z_q;
  logic           add_start_q;
  logic [31:0]    add_a_q;
  logic [31:0]    add_b_q;
  logic           add_a_stb_q;
  logic           add_b_stb_q;
  logic           add_z_ack_q;
  logic           busy_q;
  logic [15:0]    ops_done_q;

  logic           gnt_found_d;
  logic [IDW-1:0] gnt_id_d;
  logic [31:0]    gnt_a_d;
  logic [31:0]    gnt_b_d;

  // Search starts just after the last grant, so the previous winner is considered last.
  always_comb begin
    gnt_found_d = 1'b0;
    gnt_id_d    = '0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_found_d && req_valid[IDW'((int'(ptr_q) + k) % N)]) begin
        gnt_found_d = 1'b1;
        gnt_id_d    = IDW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    gnt_a_d = '0;
    gnt_b_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id_d == IDW'(i)) begin
        gnt_a_d = req_a[32*i +: 32];
        gnt_b_d = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N - 1);
      cur_id_q    <= '0;
      req_ack_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      add_z_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      req_ack_q   <= '0;
      add_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_found_d) begin
            req_ack_q <= N'(1) << gnt_id_d;
            cur_id_q  <= gnt_id_d;
            ptr_q     <= gnt_id_d;
            add_a_q   <= gnt_a_d;
            add_b_q   <= gnt_b_d;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (add_idle) begin
            add_start_q <= 1'b1;
            add_a_stb_q <= 1'b1;
            state_q     <= SEND_A;
          end
        end
        SEND_A: begin
          if (add_a_stb_q && add_a_ack) begin
            add_a_stb_q <= 1'b0;
            add_b_stb_q <= 1'b1;
            state_q     <= SEND_B;
          end
        end
        SEND_B: begin
          if (add_b_stb_q && add_b_ack) begin
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b1;
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (add_z_stb && add_z_ack_q) begin
            rsp_z_q <= add_z;
            state_q <= WAIT_V;
          end
        end
        WAIT_V: begin
          if (add_valid && add_z_ack_q) begin
            add_z_ack_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= cur_id_q;
            ops_done_q  <= ops_done_q + 16'd1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_a_stb = add_a_stb_q;
  assign add_b_stb = add_b_stb_q;
  assign add_z_ack = add_z_ack_q;
  assign busy      = busy_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a handshaking adder model plus directed and random
// requester traffic, checked against sums computed from the requested integers.
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    req_ack;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_z;
  logic            add_start;
  logic            add_idle = 1'b1;
  logic [31:0]     add_a, add_b;
  logic            add_a_stb, add_b_stb;
  logic            add_a_ack = 1'b0;
  logic            add_b_ack = 1'b0;
  logic [31:0]     add_z = '0;
  logic            add_z_stb = 1'b0;
  logic            add_valid = 1'b0;
  logic            add_z_ack;
  logic            busy;
  logic [15:0]     ops_done;

  fp_add_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .add_start(add_start), .add_idle(add_idle), .add_a(add_a), .add_b(add_b),
    .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_valid(add_valid), .add_z_ack(add_z_ack),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ia [N];
  int ib [N];

  function automatic logic [31:0] int2fp(input int v);
    logic [31:0] m;
    logic [31:0] r;
    int p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    r = m << (23 - p);
    return {(v < 0), 8'(127 + p), r[22:0]};
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    logic [31:0] m;
    int p;
    int v;
    if (f[30:23] == 8'h0) return 0;
    p = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    v = int'(m >> (23 - p));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'hFFC00000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return int2fp(fp2int(a) + fp2int(b));
  endfunction

  // Adder model: random handshake delays, idle returns a few cycles after valid.
  int ast = 0;
  int dly = 0;
  int start_viol = 0;
  int ack_viol = 0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  initial begin
    forever begin
      @(negedge clk);
      add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_valid = 1'b0;
      if ($countones(req_ack) > 1) ack_viol++;
      if (add_start && ast != 0) start_viol++;
      if (rst) begin
        ast = 0; add_idle = 1'b1;
      end else begin
        case (ast)
          0: if (add_start) begin add_idle = 1'b0; ast = 1; dly = $urandom_range(0, 2); end
          1: if (add_a_stb) begin
               if (dly == 0) begin add_a_ack = 1'b1; opa = add_a; ast = 2; dly = $urandom_range(0, 2); end
               else dly--;
             end
          2: if (add_b_stb) begin
               if (dly == 0) begin add_b_ack = 1'b1; opb = add_b; ast = 3; dly = $urandom_range(0, 2); end
               else dly--;
             end
          3: if (add_z_ack) begin
               if (dly == 0) begin add_z = fp_sum(opa, opb); add_z_stb = 1'b1; ast = 4; dly = $urandom_range(0, 2); end
               else dly--;
             end
          4: if (dly == 0) begin add_valid = 1'b1; ast = 5; dly = $urandom_range(3, 5); end
             else dly--;
          default: if (dly <= 1) begin add_idle = 1'b1; ast = 0; end else dly--;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_req(input int i, input int a, input int b);
    ia[i] = a; ib[i] = b;
    req_a[32*i +: 32] = int2fp(a);
    req_b[32*i +: 32] = int2fp(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic put_raw(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ack(output int id);
    id = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) id = i;
        break;
      end
    end
    chk("ack_seen", 32'(id >= 0), 32'd1);
    if (id < 0) id = 0;
  endtask

  task automatic wait_rsp(output int id, output logic [31:0] z);
    logic got;
    got = 1'b0; id = 0; z = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; id = int'(rsp_id); z = rsp_z; break; end
    end
    chk("rsp_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int g, rid, t0, cnt;
    logic [31:0] z, e;
    int exp_id_q [$];
    logic [31:0] exp_z_q [$];
    int n_rsp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_rsp", {rsp_valid, 29'd0, rsp_id}, 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_strobes", {add_start, add_a_stb, add_b_stb, add_z_ack, busy}, 32'd0);
    chk("rst_add_ops", add_a | add_b, 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b0;

    // Single add
    put_req(0, 1, 2);
    wait_ack(g);
    chk("single_ack", 32'(req_ack), 32'b0001);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_ack_pulse", 32'(req_ack), 32'd0);
    wait_rsp(rid, z);
    chk("single_id", 32'(rid), 32'd0);
    chk("single_z", z, 32'h40400000);
    chk("single_ops_done", 32'(ops_done), 32'd1);
    @(negedge clk);
    chk("single_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Round robin from a fresh pointer
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) put_req(i, i + 1, 10 * (i + 1));
    for (int k = 0; k < 5; k++) begin
      wait_ack(g);
      chk("rr_grant", 32'(g), 32'(k % N));
      e = int2fp(ia[g] + ib[g]);
      put_req(g, 100 + k, 7 * k - 50);
      wait_rsp(rid, z);
      chk("rr_id", 32'(rid), 32'(g));
      chk("rr_z", z, e);
    end
    req_valid = '0;

    // Late requester arrives while requester 0 waits on the result
    put_req(0, 5, 9);
    wait_ack(g);
    req_valid[0] = 1'b0;
    for (int c = 0; c < 60 && !add_z_ack; c++) @(negedge clk);
    chk("late_wait_z", 32'(add_z_ack), 32'd1);
    put_req(2, -30, 12);
    wait_rsp(rid, z);
    t0 = cyc;
    chk("late_first_id", 32'(rid), 32'd0);
    chk("late_first_z", z, int2fp(14));
    wait_ack(g);
    chk("late_grant", 32'(req_ack), 32'b0100);
    chk("late_grant_cycle", 32'(cyc - t0), 32'd2);
    req_valid[2] = 1'b0;
    wait_rsp(rid, z);
    chk("late_id", 32'(rid), 32'd2);
    chk("late_z", z, int2fp(-18));

    // Special values
    put_raw(1, 32'h7F800000, 32'hFF800000);
    wait_ack(g); req_valid[1] = 1'b0;
    wait_rsp(rid, z);
    chk("inf_id", 32'(rid), 32'd1);
    chk("inf_z", z, 32'hFFC00000);
    put_raw(3, 32'h3F800000, 32'hBF800000);
    wait_ack(g); req_valid[3] = 1'b0;
    wait_rsp(rid, z);
    chk("zero_id", 32'(rid), 32'd3);
    chk("zero_z", z, 32'h00000000);

    // Reset during SEND_B
    put_req(1, 5, 6);
    wait_ack(g); req_valid[1] = 1'b0;
    for (int c = 0; c < 60 && !add_b_stb; c++) @(negedge clk);
    chk("midrst_in_send_b", 32'(add_b_stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strobes", {add_start, add_a_stb, add_b_stb, add_z_ack, rsp_valid}, 32'd0);
    chk("midrst_ops", add_a | add_b, 32'd0);
    chk("midrst_ops_done", 32'(ops_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) cnt++; end
    chk("midrst_no_rsp", 32'(cnt), 32'd0);
    put_req(1, 3, 4);
    wait_ack(g); req_valid[1] = 1'b0;
    chk("midrst_fresh_grant", 32'(g), 32'd1);
    wait_rsp(rid, z);
    chk("midrst_fresh_z", z, int2fp(7));
    chk("midrst_fresh_cnt", 32'(ops_done), 32'd1);

    // Counter wrap
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    chk("wrap_preload", 32'(ops_done), 32'hFFFF);
    put_req(2, 8, 8);
    wait_ack(g); req_valid[2] = 1'b0;
    wait_rsp(rid, z);
    chk("wrap_z", z, int2fp(16));
    chk("wrap_ops_done", 32'(ops_done), 32'd0);

    // Random traffic with withdrawals
    n_rsp = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ack[i]) g = i;
        chk("rnd_ack_requested", 32'(req_valid[g]), 32'd1);
        exp_id_q.push_back(g);
        exp_z_q.push_back(int2fp(ia[g] + ib[g]));
        req_valid[g] = 1'b0;
      end
      if (rsp_valid) begin
        n_rsp++;
        chk("rnd_rsp_expected", 32'(exp_id_q.size() != 0), 32'd1);
        if (exp_id_q.size() != 0) begin
          chk("rnd_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
          chk("rnd_z", rsp_z, exp_z_q.pop_front());
        end
      end
      if (c < 550) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0)
            put_req(i, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
          else if (req_valid[i] && $urandom_range(0, 31) == 0)
            req_valid[i] = 1'b0;
        end
      end else begin
        req_valid = '0;
      end
    end
    chk("rnd_drained", 32'(exp_id_q.size()), 32'd0);
    chk("rnd_idle", 32'(busy), 32'd0);
    chk("rnd_activity", 32'(n_rsp > 15), 32'd1);
    chk("start_while_busy", 32'(start_viol), 32'd0);
    chk("multi_hot_ack", 32'(ack_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one single-precision FP adder between N requesters. It grants one requester at a time and latches that requester's operands. It then drives the adder's start / operand-A / operand-B / result handshakes in order, and returns the sum to the granted requester tagged with its index. It sits between the FPU adder and the client blocks (CPU execute stage, DSP loops) that issue add operations.

## Interface
- N, 4: number of requesters, 2..8.
- IDW, 2: width of requester index, ceil(log2 N).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N  per-requester request; held high until req_ack.
- req_a  in  32*N  operand A, requester i at bits [32i+31:32i].
- req_b  in  32*N  operand B, same packing.
- req_ack  out  N  one-hot, one-cycle pulse: operands of requester i captured.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_id  out  IDW  index of requester owning rsp_z.
- rsp_z  out  32  IEEE-754 sum.
- add_start  out  1  start pulse to adder.
- add_idle  in  1  adder idle status.
- add_a, add_b  out  32  operands to adder.
- add_a_stb, add_b_stb  out  1  operand strobes.
- add_a_ack, add_b_ack  in  1  adder operand acknowledges.
- add_z  in  32  adder result.
- add_z_stb  in  1  adder result strobe.
- add_valid  in  1  adder output-valid flag.
- add_z_ack  out  1  result/valid acknowledge to adder.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  16  completed operations, wraps 0xFFFF->0.

## Operation
- States: IDLE, START, SEND_A, SEND_B, WAIT_Z, WAIT_V, RESP.
- IDLE: if any req_valid, grant the first set bit searching from ptr+1 modulo N. Latch the operands into op_a/op_b and the index into cur_id. Pulse req_ack[cur_id]. Set ptr<=cur_id and go to START. Grant and ack occur in the same cycle as the decision.
- START: wait until add_idle=1. In that cycle assert add_start for exactly one cycle, then go to SEND_A.
- SEND_A: add_a=op_a and add_a_stb=1. When add_a_stb && add_a_ack, drop the strobe and go to SEND_B.
- SEND_B: same, using op_b, add_b_stb and add_b_ack. Then go to WAIT_Z.
- WAIT_Z: add_z_ack=1. When add_z_stb && add_z_ack, latch add_z into rsp_z and go to WAIT_V.
- WAIT_V: add_z_ack=1. When add_valid && add_z_ack, go to RESP.
- RESP: add_z_ack=0. Pulse rsp_valid with rsp_id=cur_id, increment ops_done, go to IDLE.
- The round-robin pointer is updated only on grant.
- Requesters may deassert req_valid after req_ack. A request withdrawn before grant is simply not granted.
- A requester that is re-requesting after its own grant has lowest priority on the next arbitration.
- add_a and add_b hold the latched operands in all states. add_a_stb and add_b_stb are 0 outside SEND_A and SEND_B.
- No timeouts: a stalled adder stalls the arbiter indefinitely with busy=1.

## Timing
- Reset values:
  - state=IDLE, ptr=N-1 (requester 0 wins first).
  - req_ack=0, rsp_valid=0, rsp_id=0, rsp_z=0.
  - add_start=0, add_a_stb=0, add_b_stb=0, add_z_ack=0, add_a=0, add_b=0.
  - busy=0, ops_done=0.
- All outputs are registered and change only on clk.
- Reset mid-operation (rst high in any state): all of the above apply the next cycle, the pending operation is discarded, and no rsp_valid is issued. The adder shares rst and returns to its own idle.
- Throughput: at most one operation in flight. The next grant occurs in the cycle after RESP.
- Minimum latency, req_ack to rsp_valid, is set by the adder handshakes plus 1 cycle each for START and RESP.
- After RESP, START waits for add_idle, which rises at least 2 cycles after the adder leaves its valid phase. add_start must never be issued while add_idle=0.
- Simultaneous requests: exactly one req_ack bit per grant, never two.
- A request arriving in the same cycle as RESP is considered in the following IDLE cycle.

## Test plan
- Single add: req_valid=0001, a=0x3F800000, b=0x40000000 -> req_ack=0001 one cycle, then rsp_valid with rsp_id=0, rsp_z=0x40400000, ops_done=1.
- Round robin: all four requesters held valid, each with distinct operands -> grants in order 0,1,2,3,0; each rsp_id matches its operands' sum.
- Late requester: requester 2 raises req_valid during requester 0's WAIT_Z -> granted immediately after requester 0's RESP.
- Special cases: 0x7F800000+0xFF800000 -> rsp_z=0xFFC00000; 0x3F800000+0xBF800000 -> rsp_z=0x00000000.
- Reset mid-op: assert rst during SEND_B -> next cycle busy=0, no rsp_valid, all add_* strobes 0. A fresh request then completes correctly.
- Counter wrap: preload ops_done to 0xFFFF by forcing, complete one op -> ops_done=0x0000.
